// File: rtl/stream_fifo.sv
// stream_fifo: show-ahead circular-buffer FIFO between two peek/consume
// streams. Ports: clock, reset (async, active-low), in_canPeek/in_peek/
// in_consume_en (upstream), out_canPeek/out_peek/out_consume_en
// (downstream). Optional macro STREAM_FIFO_LEVEL_EN adds output
// level [DEPTH_LOG2:0] = current occupancy.
module stream_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_canPeek,
  input  logic [WIDTH-1:0] in_peek,
  output logic             in_consume_en,
  output logic             out_canPeek,
  output logic [WIDTH-1:0] out_peek,
  input  logic             out_consume_en
`ifdef STREAM_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE =
    {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];

  // Extra MSB is the wrap bit that tells full from empty.
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // Gated by reset so nothing is taken while reset is held low.
  assign push = in_canPeek & ~full & reset;
  assign pop  = out_consume_en & ~empty;

  assign in_consume_en = push;
  assign out_canPeek   = ~empty;
  assign out_peek      = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not cleared on reset; the pointers alone define contents.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_peek;
  end

`ifdef STREAM_FIFO_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed self-checking bench for stream_fifo.
// Covers reset, latency, full, drain, streaming wrap, async reset.
module tb_stream_fifo;

  logic       clock;
  logic       reset;
  logic       in_canPeek;
  logic [7:0] in_peek;
  logic       in_consume_en;
  logic       out_canPeek;
  logic [7:0] out_peek;
  logic       out_consume_en;
`ifdef STREAM_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int total;
  int bad;

  stream_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_canPeek     (in_canPeek),
    .in_peek        (in_peek),
    .in_consume_en  (in_consume_en),
    .out_canPeek    (out_canPeek),
    .out_peek       (out_peek),
    .out_consume_en (out_consume_en)
`ifdef STREAM_FIFO_LEVEL_EN
    ,
    .level          (level)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    int idx;
    int nout;
    int nin;
    int max_occ;
    logic [7:0] q [$];

    total = 0;
    bad = 0;
    reset = 1'b0;
    in_canPeek = 1'b1;
    in_peek = 8'h41;
    out_consume_en = 1'b0;

    // Held in reset: nothing accepted, nothing visible.
    step();
    step();
    chk("rst_can", 32'(out_canPeek), 0);
    chk("rst_cons", 32'(in_consume_en), 0);

    // Release mid-cycle: accept is combinational, data one cycle later.
    reset = 1'b1;
    #1;
    chk("first_cons", 32'(in_consume_en), 1);
    chk("first_can0", 32'(out_canPeek), 0);
    step();
    in_canPeek = 1'b0;
    chk("first_can", 32'(out_canPeek), 1);
    chk("first_peek", 32'(out_peek), 32'h41);
    out_consume_en = 1'b1;
    step();
    chk("drain1", 32'(out_canPeek), 0);

    // Pop while empty is ignored; next push is seen correctly.
    step();
    step();
    chk("empty_pop", 32'(out_canPeek), 0);
    out_consume_en = 1'b0;
    in_canPeek = 1'b1;
    in_peek = 8'h55;
    step();
    in_canPeek = 1'b0;
    chk("after_ep", 32'(out_peek), 32'h55);
    out_consume_en = 1'b1;
    step();
    out_consume_en = 1'b0;
    chk("after_ep_e", 32'(out_canPeek), 0);

    // Fill: offer 0x00..0x10, only 16 fit.
    acc = 0;
    idx = 0;
    in_canPeek = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_peek = 8'(idx);
      #1;
      if (in_consume_en) begin
        acc++;
        idx++;
      end
      step();
    end
    in_peek = 8'(idx);
    #1;
    chk("full_acc", 32'(acc), 16);
    chk("full_cons", 32'(in_consume_en), 0);
    chk("full_pend", 32'(in_peek), 32'h10);
    chk("full_head", 32'(out_peek), 32'h00);
`ifdef STREAM_FIFO_LEVEL_EN
    chk("full_lvl", 32'(level), 16);
`endif

    // One pop from full: no same-cycle bypass.
    out_consume_en = 1'b1;
    #1;
    chk("nobypass", 32'(in_consume_en), 0);
    step();
    out_consume_en = 1'b0;
    chk("pop_head", 32'(out_peek), 32'h01);
    chk("refill", 32'(in_consume_en), 1);
    step();
    in_canPeek = 1'b0;
    chk("refull", 32'(in_consume_en), 0);

    // Drain 0x01..0x10 in order.
    out_consume_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("drain_can", 32'(out_canPeek), 1);
      chk("drain_val", 32'(out_peek), 32'(k));
      step();
    end
    out_consume_en = 1'b0;
    chk("drain_end", 32'(out_canPeek), 0);

    // Stream 40 bytes with both sides held active.
    nin = 0;
    nout = 0;
    max_occ = 0;
    in_canPeek = 1'b1;
    out_consume_en = 1'b1;
    for (int c = 0; c < 60 && nout < 40; c++) begin
      in_canPeek = (nin < 40);
      in_peek = 8'(8'h80 + nin);
      #1;
      if (out_canPeek) begin
        chk("stream", 32'(out_peek), 32'(q[0]));
        void'(q.pop_front());
        nout++;
      end
      if (in_consume_en) begin
        q.push_back(in_peek);
        nin++;
      end
      if (q.size() > max_occ) max_occ = q.size();
      step();
    end
    chk("stream_n", 32'(nout), 40);
    chk("stream_occ", 32'(max_occ), 1);
    chk("stream_e", 32'(out_canPeek), 0);
    in_canPeek = 1'b0;
    out_consume_en = 1'b0;

    // Five held, then async reset mid-cycle.
    in_canPeek = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_peek = 8'(8'hA0 + k);
      step();
    end
    chk("five_head", 32'(out_peek), 32'hA0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_can", 32'(out_canPeek), 0);
    chk("arst_cons", 32'(in_consume_en), 0);
    step();
    in_canPeek = 1'b0;
    reset = 1'b1;
    step();
    chk("arst_empty", 32'(out_canPeek), 0);
    in_canPeek = 1'b1;
    in_peek = 8'h77;
    step();
    in_canPeek = 1'b0;
    chk("arst_new", 32'(out_peek), 32'h77);
`ifdef STREAM_FIFO_LEVEL_EN
    chk("arst_lvl", 32'(level), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
